// File: rtl/spi_ram_arbiter_pkg.sv
// spi_ram_pkg
//   Shared types for the SPI/host RAM arbiter: SPI command encoding,
//   arbiter FSM states, requester identity and the round-robin pick.
// Ports: none (package).

package spi_ram_pkg;

  // Command field carried in rx_data[9:8] of every SPI slave word.
  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ARB       = 3'd0,
    ACC_SPI   = 3'd1,
    ACC_HOST  = 3'd2,
    CAPT_SPI  = 3'd3,
    CAPT_HOST = 3'd4
  } arb_state_e;

  typedef enum logic {
    SPI  = 1'b0,
    HOST = 1'b1
  } requester_e;

  localparam int CMD_W = 2;

  // On a tie the side that was not served last wins; otherwise whoever asks.
  // The result is only meaningful when at least one request is set.
  function automatic requester_e rr_pick(input logic spi_req,
                                         input logic host_req,
                                         input requester_e last);
    if (spi_req && host_req) begin
      return (last == HOST) ? SPI : HOST;
    end else if (host_req) begin
      return HOST;
    end else begin
      return SPI;
    end
  endfunction

endpackage

// File: rtl/spi_ram_arbiter_if.sv
// spi_ram_arbiter_if
//   Local host access port into the shared RAM.
//   req/we/addr/wdata : request, held by the host until gnt
//   gnt               : one-cycle pulse, request consumed
//   rdata/rvalid      : read data, rvalid is a one-cycle pulse
// Modports: master = host side, slave = arbiter side.

interface spi_ram_arbiter_if #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8
) ();

  logic                 req;
  logic                 we;
  logic [ADDR_SIZE-1:0] addr;
  logic [DATA_SIZE-1:0] wdata;
  logic                 gnt;
  logic [DATA_SIZE-1:0] rdata;
  logic                 rvalid;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rdata, rvalid
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rdata, rvalid
  );

endinterface

// File: rtl/spi_ram_arbiter_cmd_capture.sv
// spi_cmd_capture
//   Turns the level-style SPI slave word into single commands: detects the
//   rising edge of rx_valid, decodes the command field, keeps the write and
//   read address latches and holds at most one pending RAM access.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   rx_data, rx_valid     : word and level from the SPI slave
//   pend_clr              : arbiter is performing the pending access
//   rd_vld_clr            : arbiter has returned read data, read address used
//   pend, pend_we,
//   pend_addr, pend_wdata : pending access for the arbiter
//   rd_nack               : combinational; RD_DATA seen with no read address
//   cmd_err               : one-cycle pulse on a protocol error

module spi_cmd_capture
  import spi_ram_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_SIZE+1:0]   rx_data,
  input  logic                   rx_valid,
  input  logic                   pend_clr,
  input  logic                   rd_vld_clr,
  output logic                   pend,
  output logic                   pend_we,
  output logic [ADDR_SIZE-1:0]   pend_addr,
  output logic [DATA_SIZE-1:0]   pend_wdata,
  output logic                   rd_nack,
  output logic                   cmd_err
);

  logic                 rx_valid_q;
  logic                 rise;
  logic                 busy;
  cmd_e                 cmd;
  logic [DATA_SIZE-1:0] payload;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic                 rd_addr_vld;

  assign rise    = rx_valid & ~rx_valid_q;
  assign cmd     = cmd_e'(rx_data[DATA_SIZE+CMD_W-1:DATA_SIZE]);
  assign payload = rx_data[DATA_SIZE-1:0];

  // A pending entry being consumed this very cycle counts as free, so a
  // capture landing on the clearing cycle is accepted (set wins).
  assign busy    = pend & ~pend_clr;

  assign rd_nack = rise & ~busy & (cmd == RD_DATA) & ~rd_addr_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q  <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      rd_addr_vld <= 1'b0;
      pend        <= 1'b0;
      pend_we     <= 1'b0;
      pend_addr   <= '0;
      pend_wdata  <= '0;
      cmd_err     <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      cmd_err    <= 1'b0;

      if (pend_clr) begin
        pend <= 1'b0;
      end
      if (rd_vld_clr) begin
        rd_addr_vld <= 1'b0;
      end

      if (rise) begin
        if (busy) begin
          cmd_err <= 1'b1;
        end else begin
          unique case (cmd)
            WR_ADDR: begin
              wr_addr <= payload[ADDR_SIZE-1:0];
            end
            RD_ADDR: begin
              rd_addr     <= payload[ADDR_SIZE-1:0];
              rd_addr_vld <= 1'b1;
            end
            WR_DATA: begin
              pend       <= 1'b1;
              pend_we    <= 1'b1;
              pend_addr  <= wr_addr;
              pend_wdata <= payload;
            end
            RD_DATA: begin
              if (rd_addr_vld) begin
                pend       <= 1'b1;
                pend_we    <= 1'b0;
                pend_addr  <= rd_addr;
                pend_wdata <= '0;
              end else begin
                cmd_err <= 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter
//   Shares one single-port RAM between the SPI slave command path and a
//   local host port using round-robin arbitration.
// Ports:
//   clk, rst_n                : clock, async active-low reset
//   spi_rx_data, spi_rx_valid : 10-bit word {cmd, payload} and its level
//   spi_tx_data, spi_tx_valid : read data back to the slave, held while
//                               spi_rx_valid stays high
//   host                      : host request/grant/read-data interface
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata      : RAM port, read data one cycle after mem_en
//   cmd_err                   : one-cycle pulse on an SPI protocol error
//
// state     | meaning
// ----------+---------------------------------------------------------
// ARB       | idle, choose between pending SPI access and host request
// ACC_SPI   | RAM strobe for the SPI access, pending entry consumed
// ACC_HOST  | RAM strobe for the host access, host_gnt high
// CAPT_SPI  | RAM read data returned to the SPI slave (if still selected)
// CAPT_HOST | RAM read data latched for the host

module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE+1:0] spi_rx_data,
  input  logic                 spi_rx_valid,
  output logic [DATA_SIZE-1:0] spi_tx_data,
  output logic                 spi_tx_valid,
  spi_ram_arbiter_if.slave     host,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  output logic                 cmd_err
);

  arb_state_e           state;
  arb_state_e           state_nxt;
  requester_e           rr_last;
  requester_e           pick;
  logic                 grant_spi;
  logic                 grant_host;

  logic                 spi_pend;
  logic                 pend_we;
  logic [ADDR_SIZE-1:0] pend_addr;
  logic [DATA_SIZE-1:0] pend_wdata;
  logic                 rd_nack;

  logic [DATA_SIZE-1:0] host_rdata_q;
  logic                 host_rvalid_q;

  spi_cmd_capture #(
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_SIZE (DATA_SIZE)
  ) u_capture (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (spi_rx_data),
    .rx_valid   (spi_rx_valid),
    .pend_clr   (state == ACC_SPI),
    .rd_vld_clr (state == CAPT_SPI),
    .pend       (spi_pend),
    .pend_we    (pend_we),
    .pend_addr  (pend_addr),
    .pend_wdata (pend_wdata),
    .rd_nack    (rd_nack),
    .cmd_err    (cmd_err)
  );

  // Strobes come straight from the state register, so reset drops them
  // immediately and they last exactly one cycle.
  assign mem_en      = (state == ACC_SPI) || (state == ACC_HOST);
  assign host.gnt    = (state == ACC_HOST);
  assign host.rdata  = host_rdata_q;
  assign host.rvalid = host_rvalid_q;

  always_comb begin
    state_nxt  = state;
    grant_spi  = 1'b0;
    grant_host = 1'b0;
    pick       = rr_pick(spi_pend, host.req, rr_last);

    unique case (state)
      ARB: begin
        if (spi_pend || host.req) begin
          if (pick == SPI) begin
            state_nxt = ACC_SPI;
            grant_spi = 1'b1;
          end else begin
            state_nxt  = ACC_HOST;
            grant_host = 1'b1;
          end
        end
      end
      ACC_SPI:   state_nxt = mem_we ? ARB : CAPT_SPI;
      ACC_HOST:  state_nxt = mem_we ? ARB : CAPT_HOST;
      CAPT_SPI:  state_nxt = ARB;
      CAPT_HOST: state_nxt = ARB;
      default:   state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ARB;
      rr_last       <= HOST;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      spi_tx_data   <= '0;
      spi_tx_valid  <= 1'b0;
    end else begin
      state <= state_nxt;

      // RAM command fields are only non-zero during the access cycle.
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if (grant_spi) begin
        mem_we    <= pend_we;
        mem_addr  <= pend_addr;
        mem_wdata <= pend_wdata;
      end else if (grant_host) begin
        mem_we    <= host.we;
        mem_addr  <= host.addr;
        mem_wdata <= host.wdata;
      end

      if (state == ACC_SPI) begin
        rr_last <= SPI;
      end else if (state == ACC_HOST) begin
        rr_last <= HOST;
      end

      host_rvalid_q <= (state == CAPT_HOST);
      if (state == CAPT_HOST) begin
        host_rdata_q <= mem_rdata;
      end

      // Once the slave lets go of rx_valid the transaction is over; read
      // data arriving after that is simply dropped.
      if (!spi_rx_valid) begin
        spi_tx_valid <= 1'b0;
      end else if (state == CAPT_SPI) begin
        spi_tx_data  <= mem_rdata;
        spi_tx_valid <= 1'b1;
      end else if (rd_nack) begin
        spi_tx_data  <= '0;
        spi_tx_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter
//   Directed bench for spi_ram_arbiter with a behavioural RAM behind the
//   memory port. Inputs change 1 time unit after a rising edge and outputs
//   are sampled there as well.

module tb_spi_ram_arbiter;

  logic       clk;
  logic       rst_n;
  logic [9:0] spi_rx_data;
  logic       spi_rx_valid;
  logic [7:0] spi_tx_data;
  logic       spi_tx_valid;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       cmd_err;

  logic [7:0] ram [256];
  int         mem_en_cnt;
  int         cnt0;
  int         n_chk;
  int         n_bad;

  spi_ram_arbiter_if #(.ADDR_SIZE(8), .DATA_SIZE(8)) host_bus ();

  spi_ram_arbiter #(.ADDR_SIZE(8), .DATA_SIZE(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_rx_data  (spi_rx_data),
    .spi_rx_valid (spi_rx_valid),
    .spi_tx_data  (spi_tx_data),
    .spi_tx_valid (spi_tx_valid),
    .host         (host_bus),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .cmd_err      (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      mem_en_cnt <= mem_en_cnt + 1;
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spi_word(input logic [1:0] c, input logic [7:0] p);
    spi_rx_data  = {c, p};
    spi_rx_valid = 1'b1;
  endtask

  task automatic host_rd(input logic [7:0] a);
    host_bus.req   = 1'b1;
    host_bus.we    = 1'b0;
    host_bus.addr  = a;
    host_bus.wdata = 8'h00;
  endtask

  initial begin
    n_chk        = 0;
    n_bad        = 0;
    mem_en_cnt   = 0;
    mem_rdata    = 8'h00;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[8'h10]   = 8'h77;
    rst_n        = 1'b0;
    spi_rx_data  = 10'h000;
    spi_rx_valid = 1'b0;
    host_bus.req   = 1'b0;
    host_bus.we    = 1'b0;
    host_bus.addr  = 8'h00;
    host_bus.wdata = 8'h00;

    // reset state
    tick; tick;
    chk("rst_strobes", 32'({mem_en, mem_we, spi_tx_valid, host_bus.gnt, host_bus.rvalid, cmd_err}), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    rst_n = 1'b1;
    tick;

    // SPI write: WR_ADDR 0x3C then WR_DATA 0xA5
    spi_word(2'b00, 8'h3C); tick; spi_rx_valid = 1'b0; tick;
    spi_word(2'b01, 8'hA5); tick; tick;
    chk("wr_mem_en",    32'(mem_en), 1);
    chk("wr_mem_we",    32'(mem_we), 1);
    chk("wr_mem_addr",  32'(mem_addr), 32'h3C);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'hA5);
    tick;
    chk("wr_mem_en_one", 32'(mem_en), 0);
    spi_rx_valid = 1'b0; tick;

    // SPI read: RD_ADDR 0x3C then RD_DATA
    spi_word(2'b10, 8'h3C); tick; spi_rx_valid = 1'b0; tick;
    spi_word(2'b11, 8'h00); tick; tick;
    chk("rd_mem_en",   32'(mem_en), 1);
    chk("rd_mem_we",   32'(mem_we), 0);
    chk("rd_mem_addr", 32'(mem_addr), 32'h3C);
    tick;
    chk("rd_tx_early", 32'(spi_tx_valid), 0);
    tick;
    chk("rd_tx_valid", 32'(spi_tx_valid), 1);
    chk("rd_tx_data",  32'(spi_tx_data), 32'hA5);
    tick; tick;
    chk("rd_tx_hold", 32'(spi_tx_valid), 1);
    spi_rx_valid = 1'b0;
    tick;
    chk("rd_tx_clear", 32'(spi_tx_valid), 0);

    // RD_DATA after reset without RD_ADDR
    rst_n = 1'b0; tick; rst_n = 1'b1; tick;
    cnt0 = mem_en_cnt;
    spi_word(2'b11, 8'h00); tick;
    chk("nack_tx_valid", 32'(spi_tx_valid), 1);
    chk("nack_tx_data",  32'(spi_tx_data), 0);
    chk("nack_err",      32'(cmd_err), 1);
    tick;
    chk("nack_err_pulse", 32'(cmd_err), 0);
    tick; tick;
    chk("nack_no_mem", 32'(mem_en_cnt - cnt0), 0);
    spi_rx_valid = 1'b0; tick;
    chk("nack_tx_clear", 32'(spi_tx_valid), 0);

    // tie after reset: SPI first, then host
    rst_n = 1'b0; tick; rst_n = 1'b1; tick;
    spi_word(2'b01, 8'h55); tick;
    host_rd(8'h10); tick;
    chk("tie1_spi_en",   32'(mem_en), 1);
    chk("tie1_spi_we",   32'(mem_we), 1);
    chk("tie1_spi_addr", 32'(mem_addr), 0);
    chk("tie1_no_gnt",   32'(host_bus.gnt), 0);
    tick;
    chk("tie1_arb_gap", 32'(host_bus.gnt), 0);
    tick;
    chk("tie1_host_gnt",  32'(host_bus.gnt), 1);
    chk("tie1_host_addr", 32'(mem_addr), 32'h10);
    host_bus.req = 1'b0; tick; tick;
    chk("tie1_rvalid", 32'(host_bus.rvalid), 1);
    chk("tie1_rdata",  32'(host_bus.rdata), 32'h77);
    spi_rx_valid = 1'b0; tick;

    // SPI alone, then a tie must go to the host
    spi_word(2'b01, 8'h66); tick; tick;
    chk("solo_spi_en", 32'(mem_en), 1);
    tick; spi_rx_valid = 1'b0; tick;
    spi_word(2'b01, 8'h99); tick;
    host_rd(8'h10); tick;
    chk("tie2_host_gnt", 32'(host_bus.gnt), 1);
    chk("tie2_host_we",  32'(mem_we), 0);
    host_bus.req = 1'b0; tick; tick;
    chk("tie2_rvalid", 32'(host_bus.rvalid), 1);
    tick;
    chk("tie2_spi_en",    32'(mem_en), 1);
    chk("tie2_spi_wdata", 32'(mem_wdata), 32'h99);
    spi_rx_valid = 1'b0; tick;

    // host read alone: gnt at N+1, rvalid at N+3
    host_rd(8'h10); tick;
    chk("h_gnt",      32'(host_bus.gnt), 1);
    chk("h_mem_addr", 32'(mem_addr), 32'h10);
    host_bus.req = 1'b0; tick;
    chk("h_gnt_pulse",    32'(host_bus.gnt), 0);
    chk("h_rvalid_early", 32'(host_bus.rvalid), 0);
    tick;
    chk("h_rvalid", 32'(host_bus.rvalid), 1);
    chk("h_rdata",  32'(host_bus.rdata), 32'h77);
    tick;
    chk("h_rvalid_pulse", 32'(host_bus.rvalid), 0);

    // second SPI word while one is pending is dropped
    cnt0 = mem_en_cnt;
    host_rd(8'h10); spi_word(2'b01, 8'h11); tick;
    chk("drop_gnt", 32'(host_bus.gnt), 1);
    host_bus.req = 1'b0; spi_rx_valid = 1'b0; tick;
    spi_word(2'b01, 8'h22); tick;
    chk("drop_err", 32'(cmd_err), 1);
    tick;
    chk("drop_spi_en",    32'(mem_en), 1);
    chk("drop_keep_data", 32'(mem_wdata), 32'h11);
    spi_rx_valid = 1'b0; tick; tick; tick;
    chk("drop_acc_count", 32'(mem_en_cnt - cnt0), 2);

    // reset during ACC_SPI of a read
    spi_word(2'b10, 8'h3C); tick; spi_rx_valid = 1'b0; tick;
    spi_word(2'b11, 8'h00); tick; tick;
    chk("arst_pre_en", 32'(mem_en), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_strobes", 32'({mem_en, mem_we, spi_tx_valid, host_bus.gnt, cmd_err}), 0);
    chk("arst_addr",    32'(mem_addr), 0);
    spi_rx_valid = 1'b0;
    tick;
    rst_n = 1'b1;
    cnt0 = mem_en_cnt;
    repeat (5) tick;
    chk("arst_no_tx",  32'(spi_tx_valid), 0);
    chk("arst_no_mem", 32'(mem_en_cnt - cnt0), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
- Sequences the single-port RAM behind the SPI slave, sharing it with a local host port.
- Decodes 10-bit SPI slave words (rx_data[9:8] = command, rx_data[7:0] = payload) into RAM address latches, writes and reads.
- Returns SPI read data on spi_tx_data/spi_tx_valid.
- Round-robin arbitrates the single RAM port between the SPI path and host requests.

Parameters:
ADDR_SIZE, 8, RAM address width
DATA_SIZE, 8, RAM data width (must equal rx payload width)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
spi_rx_data  in  10  word from SPI slave; held stable while spi_rx_valid high
spi_rx_valid  in  1  level from slave; stays high until slave returns to IDLE
spi_tx_data  out  DATA_SIZE  read data to slave
spi_tx_valid  out  1  read data valid; held until spi_rx_valid falls
host_req  in  1  host access request; held with we/addr/wdata until host_gnt
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_SIZE  host address
host_wdata  in  DATA_SIZE  host write data
host_gnt  out  1  one-cycle pulse; request consumed
host_rdata  out  DATA_SIZE  host read data
host_rvalid  out  1  one-cycle pulse; host_rdata valid
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_SIZE  RAM address
mem_wdata  out  DATA_SIZE  RAM write data
mem_rdata  in  DATA_SIZE  RAM read data, valid the cycle after mem_en
cmd_err  out  1  one-cycle pulse on protocol error

Behaviour:
- Reset (async, any time): all outputs 0; FSM = ARB; wr_addr = rd_addr = 0; rd_addr_vld = 0; spi_pend = 0; rr_last = HOST (SPI wins first tie). In-flight access and pending command are discarded.
- Capture: a rising edge of spi_rx_valid (registered compare) captures spi_rx_data.
- Command decode:
  - 00 WR_ADDR: wr_addr <= payload; no RAM access.
  - 10 RD_ADDR: rd_addr <= payload; rd_addr_vld <= 1; no RAM access.
  - 01 WR_DATA: spi_pend set, op = write, address wr_addr.
  - 11 RD_DATA: spi_pend set, op = read, address rd_addr.
- RD_DATA with rd_addr_vld = 0: no RAM access; spi_tx_data = 0 and spi_tx_valid = 1 on the next cycle, so the slave never stalls; cmd_err pulses.
- A new SPI capture while spi_pend is still set: the new word is dropped; cmd_err pulses.
- FSM states: ARB, ACC_SPI, ACC_HOST, CAPT_SPI, CAPT_HOST.
  - ARB: if spi_pend and host_req both set, grant the side opposite rr_last; else grant whichever is set; otherwise stay in ARB.
  - ACC_*: mem_en = 1, mem_we/mem_addr/mem_wdata registered, valid for exactly one cycle. host_gnt = 1 in ACC_HOST. rr_last updated. spi_pend cleared in ACC_SPI.
  - After ACC_*: write -> ARB; read -> CAPT_*.
  - CAPT_SPI: if spi_rx_valid is still 1, spi_tx_data <= mem_rdata and spi_tx_valid <= 1. If spi_rx_valid is 0 (SS_n aborted), the data is discarded. rd_addr_vld <= 0. Then -> ARB.
  - CAPT_HOST: host_rdata <= mem_rdata; host_rvalid pulses next cycle. Then -> ARB.
- spi_tx_valid clears the cycle after spi_rx_valid is sampled low. The host may be served while spi_tx_valid is held.
- Latency:
  - host_req seen in ARB at cycle N -> host_gnt/mem_en at N+1 -> host_rvalid at N+3.
  - SPI RD_DATA captured at N -> spi_tx_valid at N+4 when uncontended.
- Same-cycle spi_pend clear (ACC_SPI) and new capture: set wins.
- Addresses do not auto-increment; the width of payload and address is the same, so there is no truncation.

Decomposition:
- Package spi_ram_pkg holds:
  - cmd_e (WR_ADDR = 2'b00, WR_DATA = 2'b01, RD_ADDR = 2'b10, RD_DATA = 2'b11)
  - arb_state_e
  - requester_e (SPI, HOST)
- Sub-module spi_cmd_capture: rx_valid edge detect, decode, wr_addr/rd_addr/rd_addr_vld latches, single-entry pending register, cmd_err generation.
- The top level holds the FSM, round-robin logic and RAM/host/tx registers.

Test Plan:
- SPI WR_ADDR 0x3C, then WR_DATA 0xA5 -> one cycle with mem_en = 1, mem_we = 1, mem_addr = 0x3C, mem_wdata = 0xA5.
- SPI RD_ADDR 0x3C, RD_DATA (RAM holds 0xA5) -> mem_en = 1, mem_we = 0, mem_addr = 0x3C; spi_tx_data = 0xA5; spi_tx_valid held until spi_rx_valid drops, then cleared next cycle.
- RD_DATA after reset with no RD_ADDR -> no mem_en; spi_tx_data = 0x00; spi_tx_valid = 1; cmd_err one pulse.
- SPI WR_DATA pending and host_req read 0x10 in the same ARB cycle after reset -> SPI granted first, host_gnt next grant. Repeated ties alternate SPI/HOST.
- Host read 0x10 (RAM = 0x77) alone -> host_gnt at N+1; host_rvalid = 1 with host_rdata = 0x77 at N+3.
- rst_n asserted in ACC_SPI of a read -> outputs 0 immediately; after release, no spi_tx_valid and no stale pending access.
